load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Executes RV32I loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) from the execute stage over a
//  valid/ready data-memory port. Aligns and extends load data, then drives the register
//  file write port. Sits directly upstream of register_file (write_data / write_addr / rf_en).
//  One transaction in flight; handles misaligned-access, illegal-funct3 and bus-timeout faults.
// PARAMETERS
//  width    32   data width of memory and register file paths (RV32I: 32 only)
//  TIMEOUT  255  max cycles in REQ waiting for mem_ready; 0 disables timeout
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-low reset
//  req_valid    in   1      execute stage presents a memory op
//  req_ready    out  1      LSU accepts op (high only in IDLE)
//  req_is_load  in   1      1 = load, 0 = store
//  req_funct3   in   3      RV32I funct3 of the op
//  req_addr     in   32     effective byte address
//  req_wdata    in   width  store data (rs2)
//  req_rd       in   5      load destination register
//  mem_valid    out  1      memory request active
//  mem_ready    in   1      memory accepts/completes request this cycle
//  mem_we       out  1      1 = write
//  mem_addr     out  32     word address ({req_addr[31:2],2'b00})
//  mem_wstrb    out  4      byte write strobes (0 for loads)
//  mem_wdata    out  width  lane-replicated store data
//  mem_rdata    in   width  read data, valid when mem_valid && mem_ready && !mem_we
//  rf_en        out  1      register file write enable
//  write_addr   out  5      register file write address
//  write_data   out  width  aligned, extended load result
//  fault        out  1      one-cycle fault pulse
//  fault_cause  out  2      01 misaligned, 10 illegal funct3, 11 timeout; valid with fault
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; mem_valid, rf_en, fault, busy = 0; mem_addr, mem_wstrb,
//    mem_wdata, write_addr, write_data, fault_cause = 0; timeout counter = 0. Reset mid-
//    transaction aborts it silently (no rf_en, no fault); a pending memory response is ignored.
//  - FSM: IDLE, REQ, WB. Accept on req_valid && req_ready (IDLE only); op fields are registered.
//  - IDLE: accepted op checked first. Illegal funct3 (load: 011,110,111; store: >=011) ->
//    fault=1, cause=10 next cycle, stay IDLE. Misaligned (half: addr[0]=1; word: addr[1:0]!=0)
//    -> fault=1, cause=01 next cycle, stay IDLE. No mem_valid in either case. Else -> REQ.
//  - REQ: mem_valid=1, outputs stable until mem_ready. Store: mem_ready -> IDLE.
//    Load: mem_ready -> capture mem_rdata, -> WB. Counter increments per REQ cycle without
//    mem_ready; reaching TIMEOUT -> fault=1, cause=11, -> IDLE, mem_valid drops.
//    mem_ready on the TIMEOUT cycle wins (normal completion, no fault).
//  - WB: rf_en=1 for exactly one cycle with write_addr=rd, write_data=result; -> IDLE.
//    rd=0: memory access still performed, rf_en held 0 in WB.
//  - Load latency: accept cycle N, mem_valid from N+1; mem_ready at cycle M -> rf_en at M+1.
//    Earliest next accept: cycle after WB (store: cycle after mem_ready).
//  - Load data: byte lane = addr[1:0], half lane = addr[1]. LB/LH sign-extend; LBU/LHU
//    zero-extend; LW passes through.
//  - Store: SB wstrb=0001<<addr[1:0], wdata={4{b}}; SH wstrb=0011<<{addr[1],1'b0},
//    wdata={2{h}}; SW wstrb=1111. mem_wstrb=0 for loads.
//  - fault and rf_en never asserted in the same cycle; at most one fault per op.
// TESTING
//  1 LW rd=5 @0x100, mem_ready 3 cycles after mem_valid, rdata 0xDEADBEEF -> one rf_en pulse,
//    write_addr=5, write_data=0xDEADBEEF, cycle after mem_ready.
//  2 LB @0x103, rdata 0x80123456 -> write_data 0xFFFFFF80; LBU same -> 0x00000080;
//    LH @0x102 -> 0xFFFF8012.
//  3 SH @0x102 wdata 0x00001234 -> mem_we=1, mem_addr 0x100, wstrb 1100,
//    mem_wdata 0x12341234; no rf_en.
//  4 LW @0x101 -> fault=1, cause=01, mem_valid never high; funct3=111 load -> cause=10.
//  5 TIMEOUT=4, mem_ready held 0 -> fault cause=11 after 4 REQ cycles, back to IDLE;
//    load rd=0 with normal response -> no rf_en.
//  6 rst low during REQ with mem_ready arriving next cycle -> all outputs 0, no rf_en,
//    req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the execute-stage request channel and the data-memory channel of
//   the load/store unit.
//   slave  : the LSU side (takes requests, drives the memory request).
//   master : the environment side (execute stage plus data memory).
//   req_*  : valid/ready op from execute (is_load, funct3, addr, wdata, rd)
//   mem_*  : valid/ready word-addressed memory port with byte strobes
interface load_store_unit_if #(
    parameter int width = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_is_load;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr;
    logic [width-1:0] req_wdata;
    logic [4:0]       req_rd;

    logic             mem_valid;
    logic             mem_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_wstrb;
    logic [width-1:0] mem_wdata;
    logic [width-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_load, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_is_load, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I load/store execution over a valid/ready data-memory port, one op in
//   flight. Loads are aligned and sign/zero extended and written to the
//   register file; misaligned, illegal-funct3 and bus-timeout faults are
//   reported as a one-cycle pulse.
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : request + memory channels (load_store_unit_if.slave)
//   rf_en, write_addr, write_data : register file write port
//   fault, fault_cause : fault pulse, cause 01 misaligned / 10 funct3 / 11 timeout
//   busy        : an op is in progress
//
//   state | meaning
//   IDLE  | ready for an op; faults for rejected ops are raised from here
//   REQ   | memory request held on the bus until mem_ready or timeout
//   WB    | load result presented on the register file port for one cycle
module load_store_unit #(
    parameter int width   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output logic             rf_en,
    output logic [4:0]       write_addr,
    output logic [width-1:0] write_data,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state;
    logic [CW-1:0]    tmo_cnt;
    logic             op_is_load;
    logic [2:0]       op_funct3;
    logic [1:0]       op_lane;
    logic [4:0]       op_rd;

    logic             illegal;
    logic             misaligned;
    logic [3:0]       st_wstrb;
    logic [width-1:0] st_wdata;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [width-1:0] ld_result;

    // Decode of the op currently offered on the request channel.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        st_wstrb   = 4'b1111;
        st_wdata   = bus.req_wdata;
        if (bus.req_is_load)
            illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        else
            illegal = (bus.req_funct3 >= 3'b011);
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        case (bus.req_funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << bus.req_addr[1:0];
                st_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << {bus.req_addr[1], 1'b0};
                st_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = bus.req_wdata;
            end
        endcase
    end

    // Load alignment uses the registered lane/funct3, since the request
    // channel may already carry the next op while we wait on memory.
    always_comb begin
        ld_byte = bus.mem_rdata[{op_lane, 3'b000} +: 8];
        ld_half = bus.mem_rdata[{op_lane[1], 4'b0000} +: 16];
        case (op_funct3)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_result = {24'b0, ld_byte};
            3'b101:  ld_result = {16'b0, ld_half};
            default: ld_result = bus.mem_rdata;
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            op_is_load    <= 1'b0;
            op_funct3     <= 3'b000;
            op_lane       <= 2'b00;
            op_rd         <= 5'd0;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wstrb <= '0;
            bus.mem_wdata <= '0;
            rf_en         <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
            fault         <= 1'b0;
            fault_cause   <= 2'b00;
        end else begin
            fault <= 1'b0;
            rf_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_is_load <= bus.req_is_load;
                        op_funct3  <= bus.req_funct3;
                        op_lane    <= bus.req_addr[1:0];
                        op_rd      <= bus.req_rd;
                        tmo_cnt    <= '0;
                        if (illegal) begin
                            fault       <= 1'b1;
                            fault_cause <= 2'b10;
                        end else if (misaligned) begin
                            fault       <= 1'b1;
                            fault_cause <= 2'b01;
                        end else begin
                            state         <= REQ;
                            bus.mem_valid <= 1'b1;
                            bus.mem_we    <= !bus.req_is_load;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wstrb <= bus.req_is_load ? 4'b0000 : st_wstrb;
                            bus.mem_wdata <= bus.req_is_load ? '0 : st_wdata;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        tmo_cnt       <= '0;
                        if (op_is_load) begin
                            write_data <= ld_result;
                            write_addr <= op_rd;
                            rf_en      <= (op_rd != 5'd0);
                            state      <= WB;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (TIMEOUT != 0 && tmo_cnt == CW'(TIMEOUT - 1)) begin
                        bus.mem_valid <= 1'b0;
                        fault         <= 1'b1;
                        fault_cause   <= 2'b11;
                        tmo_cnt       <= '0;
                        state         <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Drives directed and random load/store ops into load_store_unit with a
//   responsive memory model and compares every observable result against a
//   byte/size arithmetic reference model.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rf_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.width(32)) bus ();

    load_store_unit #(.width(32), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rf_en       (rf_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .fault       (fault),
        .fault_cause (fault_cause),
        .busy        (busy)
    );

    always @(negedge clk) if (rf_en && fault) both_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model: access size in bytes, 0 = illegal encoding.
    function automatic int op_size(input bit ld, input bit [2:0] f3);
        if (ld) begin
            case (f3)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int model_cause(input bit ld, input bit [2:0] f3, input bit [31:0] a);
        int sz;
        sz = op_size(ld, f3);
        if (sz == 0) return 2;
        if (a % sz != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input bit [2:0] f3, input bit [31:0] a,
                                               input bit [31:0] rd_data);
        int sz;
        logic [31:0] v;
        sz = op_size(1'b1, f3);
        v  = rd_data >> (8 * (a % 4));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input bit [2:0] f3, input bit [31:0] w);
        int sz;
        sz = op_size(1'b0, f3);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_wstrb(input bit [2:0] f3, input bit [31:0] a);
        int sz;
        sz = op_size(1'b0, f3);
        return ((32'd1 << sz) - 32'd1) << (a % 4);
    endfunction

    task automatic issue(input bit ld, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit [4:0] rd);
        int k;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("req_ready_before_accept", bus.req_ready, 1);
        bus.req_valid   = 1'b1;
        bus.req_is_load = ld;
        bus.req_funct3  = f3;
        bus.req_addr    = a;
        bus.req_wdata   = wd;
        bus.req_rd      = rd;
        @(posedge clk); #1;
        // Scramble the channel so only registered op fields can be used.
        bus.req_valid   = 1'b0;
        bus.req_is_load = 1'($urandom);
        bus.req_funct3  = 3'($urandom);
        bus.req_addr    = $urandom;
        bus.req_wdata   = $urandom;
        bus.req_rd      = 5'($urandom);
    endtask

    task automatic run_op(input bit ld, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input bit [4:0] rd,
                          input bit [31:0] rdata, input int lat);
        int cause;
        int k;
        cause = model_cause(ld, f3, a);
        issue(ld, f3, a, wd, rd);
        if (cause != 0) begin
            chk("reject_fault", fault, 1);
            chk("reject_cause", fault_cause, cause);
            chk("reject_no_mem_valid", bus.mem_valid, 0);
            chk("reject_stays_idle", busy, 0);
            @(posedge clk); #1;
            chk("reject_fault_one_cycle", fault, 0);
            chk("reject_no_mem_valid_after", bus.mem_valid, 0);
            return;
        end
        chk("req_busy", busy, 1);
        chk("req_mem_we", bus.mem_we, !ld);
        chk("req_mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        chk("req_mem_wstrb", bus.mem_wstrb, ld ? 32'd0 : model_wstrb(f3, a));
        if (!ld) chk("req_mem_wdata", bus.mem_wdata, model_wdata(f3, wd));
        for (k = 0; k < TMO; k++) begin
            chk("req_mem_valid_held", bus.mem_valid, 1);
            chk("req_no_fault", fault, 0);
            if (k == lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rdata;
            end else begin
                bus.mem_rdata = $urandom;
            end
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            if (k == lat) break;
        end
        if (lat >= TMO) begin
            chk("timeout_fault", fault, 1);
            chk("timeout_cause", fault_cause, 3);
            chk("timeout_mem_valid_drop", bus.mem_valid, 0);
            chk("timeout_no_rf_en", rf_en, 0);
            chk("timeout_idle", busy, 0);
            @(posedge clk); #1;
            chk("timeout_fault_one_cycle", fault, 0);
            return;
        end
        chk("done_no_fault", fault, 0);
        chk("done_mem_valid_drop", bus.mem_valid, 0);
        if (ld) begin
            chk("wb_rf_en", rf_en, rd != 0);
            if (rd != 0) begin
                chk("wb_write_addr", write_addr, rd);
                chk("wb_write_data", write_data, model_load(f3, a, rdata));
            end
            @(posedge clk); #1;
            chk("wb_rf_en_one_cycle", rf_en, 0);
            chk("wb_then_ready", bus.req_ready, 1);
        end else begin
            chk("store_no_rf_en", rf_en, 0);
            chk("store_then_ready", bus.req_ready, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ld;
        bit [2:0]    f3;
        bit [31:0]   a;
        bit [4:0]    rd;

        bus.req_valid   = 1'b0;
        bus.req_is_load = 1'b0;
        bus.req_funct3  = 3'd0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.req_rd      = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = '0;

        #12;
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_rf_en", rf_en, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_mem_wstrb", bus.mem_wstrb, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", bus.req_ready, 1);

        // Directed cases.
        run_op(1'b1, 3'd2, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 3);
        run_op(1'b1, 3'd0, 32'h103, 32'h0, 5'd1, 32'h80123456, 0);
        run_op(1'b1, 3'd4, 32'h103, 32'h0, 5'd2, 32'h80123456, 1);
        run_op(1'b1, 3'd1, 32'h102, 32'h0, 5'd3, 32'h80123456, 2);
        run_op(1'b0, 3'd1, 32'h102, 32'h00001234, 5'd0, 32'h0, 1);
        run_op(1'b1, 3'd2, 32'h101, 32'h0, 5'd4, 32'h0, 0);
        run_op(1'b1, 3'd7, 32'h100, 32'h0, 5'd4, 32'h0, 0);
        run_op(1'b0, 3'd3, 32'h100, 32'h0, 5'd0, 32'h0, 0);
        run_op(1'b1, 3'd2, 32'h200, 32'h0, 5'd6, 32'h0, 9);
        run_op(1'b1, 3'd2, 32'h204, 32'h0, 5'd0, 32'h12345678, 1);

        // Random ops.
        for (int i = 0; i < 60; i++) begin
            ld = 1'($urandom);
            if ($urandom % 4 == 0) f3 = 3'($urandom);
            else if (ld) begin
                case ($urandom % 5)
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else f3 = 3'($urandom % 3);
            a  = $urandom;
            if ($urandom % 3 != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                                            (f3[1:0] == 2'b01) ? {a[1], 1'b0} : a[1:0];
            rd = 5'($urandom);
            run_op(ld, f3, a, $urandom, rd, $urandom, int'($urandom % 6));
        end

        // Reset while a load is waiting, with the response arriving.
        issue(1'b1, 3'd2, 32'h300, 32'h0, 5'd9);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        #1 rst = 1'b0;
        #1;
        chk("arst_mem_valid", bus.mem_valid, 0);
        chk("arst_mem_addr", bus.mem_addr, 0);
        chk("arst_mem_wdata", bus.mem_wdata, 0);
        chk("arst_rf_en", rf_en, 0);
        chk("arst_write_addr", write_addr, 0);
        chk("arst_write_data", write_data, 0);
        chk("arst_fault", fault, 0);
        chk("arst_fault_cause", fault_cause, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        chk("arst_no_rf_en", rf_en, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_release_ready", bus.req_ready, 1);
        chk("arst_release_no_rf_en", rf_en, 0);
        chk("arst_release_no_fault", fault, 0);
        run_op(1'b1, 3'd5, 32'h302, 32'h0, 5'd10, 32'h89AB0000, 0);

        chk("fault_and_rf_en_overlap", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
